bcd_countdown_timer: RTL and testbench



---
 rtl/bcd_countdown_timer.sv | 159 +++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// mm:ss BCD countdown timer with start/pause/load control and a one-cycle expiry pulse.
// Optional low-time warning output is built only when TIMER_WARN_EN is defined.
module bcd_countdown_timer #(
  parameter int          TICK_DIV  = 100_000_000,
  parameter logic [15:0] RESET_BCD = 16'h0300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [3:0]  cnt3,
  output logic [3:0]  cnt2,
  output logic [3:0]  cnt1,
  output logic [3:0]  cnt0,
  output logic        running,
  output logic        done,
  output logic        expire,
  output logic        warn
);

  localparam int            TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] tick_reg, tick_next;
  logic [15:0]   digits_reg, digits_next;
  logic          running_reg, running_next;
  logic          done_reg, done_next;
  logic          expire_reg, expire_next;

  // Any digit above 9 becomes 9; the seconds-tens digit is capped at 5.
  function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (r[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
    end
    if (r[7:4] > 4'd5) r[7:4] = 4'd5;
    return r;
  endfunction

  // One-second decrement with a BCD borrow chain; caller never passes 00:00.
  function automatic logic [15:0] dec_bcd(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (r[3:0] == 4'd0) begin
      r[3:0] = 4'd9;
      if (r[7:4] == 4'd0) begin
        r[7:4] = 4'd5;
        if (r[11:8] == 4'd0) begin
          r[11:8]  = 4'd9;
          r[15:12] = r[15:12] - 4'd1;
        end else begin
          r[11:8] = r[11:8] - 4'd1;
        end
      end else begin
        r[7:4] = r[7:4] - 4'd1;
      end
    end else begin
      r[3:0] = r[3:0] - 4'd1;
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      tick_reg    <= '0;
      digits_reg  <= RESET_BCD;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
      expire_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tick_reg    <= tick_next;
      digits_reg  <= digits_next;
      running_reg <= running_next;
      done_reg    <= done_next;
      expire_reg  <= expire_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    tick_next   = tick_reg;
    digits_next = digits_reg;
    expire_next = 1'b0;
    if (load) begin
      digits_next = clamp_bcd(load_val);
      tick_next   = '0;
      state_next  = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && digits_reg != 16'h0000) begin
            state_next = RUN;
            tick_next  = '0;
          end
        end
        RUN: begin
          if (pause) begin
            state_next = PAUSE;
          end else if (tick_reg == TICK_LAST) begin
            tick_next = '0;
            if (digits_reg != 16'h0000) begin
              digits_next = dec_bcd(digits_reg);
              if (digits_next == 16'h0000) begin
                state_next  = DONE;
                expire_next = 1'b1;
              end
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
        PAUSE: begin
          // A simultaneous pause keeps us frozen.
          if (start && !pause) state_next = RUN;
        end
        default: ;
      endcase
    end
    running_next = (state_next == RUN);
    done_next    = (state_next == DONE);
  end

  assign cnt3    = digits_reg[15:12];
  assign cnt2    = digits_reg[11:8];
  assign cnt1    = digits_reg[7:4];
  assign cnt0    = digits_reg[3:0];
  assign running = running_reg;
  assign done    = done_reg;
  assign expire  = expire_reg;

`ifdef TIMER_WARN_EN
  logic warn_reg, warn_next;

  always_comb begin
    warn_next = 1'b0;
    if ((state_next == RUN || state_next == PAUSE) && digits_next[15:8] == 8'h00 &&
        (digits_next[7:4] == 4'd0 || (digits_next[7:4] == 4'd1 && digits_next[3:0] == 4'd0)))
      warn_next = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) warn_reg <= 1'b0;
    else     warn_reg <= warn_next;
  end

  assign warn = warn_reg;
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: a vector table plus hand sequences, all checked
// through an expectation queue; warn expectations follow TIMER_WARN_EN.
module tb_bcd_countdown_timer;
  localparam int TD = 4;
`ifdef TIMER_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, pause, load;
  logic [15:0] load_val;
  logic [3:0]  cnt3, cnt2, cnt1, cnt0;
  logic        running, done, expire, warn;

  bcd_countdown_timer #(.TICK_DIV(TD), .RESET_BCD(16'h0300)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .load(load),
    .load_val(load_val), .cnt3(cnt3), .cnt2(cnt2), .cnt1(cnt1), .cnt0(cnt0),
    .running(running), .done(done), .expire(expire), .warn(warn)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        s, p, l;
    logic [15:0] v;
    logic [15:0] d;
    logic        run, dn, ex, wr;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(string name, logic s, logic p, logic l, logic [15:0] v,
                              logic [15:0] d, logic run, logic dn, logic ex, logic wr);
    vec_t r;
    r.name = name; r.s = s; r.p = p; r.l = l; r.v = v;
    r.d = d; r.run = run; r.dn = dn; r.ex = ex; r.wr = wr;
    return r;
  endfunction

  function automatic logic [15:0] bcd_s(int s);
    logic [15:0] r;
    r = {8'h00, 4'(s / 10), 4'(s % 10)};
    return r;
  endfunction

  task automatic check(input vec_t e);
    total++;
    if ({cnt3, cnt2, cnt1, cnt0} !== e.d || running !== e.run || done !== e.dn ||
        expire !== e.ex || warn !== e.wr) begin
      bad++;
      $display("FAIL %s: got digits=%h run=%b done=%b expire=%b warn=%b, want digits=%h run=%b done=%b expire=%b warn=%b",
               e.name, {cnt3, cnt2, cnt1, cnt0}, running, done, expire, warn,
               e.d, e.run, e.dn, e.ex, e.wr);
    end
  endtask

  // Drive one edge's worth of inputs, queue its expectation, compare on the falling edge.
  task automatic step(input vec_t e);
    start = e.s; pause = e.p; load = e.l; load_val = e.v;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0; pause = 1'b0; load = 1'b0;
    @(negedge clk);
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: got empty queue, want one entry");
    end else begin
      check(sb.pop_front());
    end
  endtask

  task automatic idle_exp(string name, logic [15:0] d, logic run, logic dn, logic ex, logic wr);
    step(mk(name, 1'b0, 1'b0, 1'b0, 16'h0, d, run, dn, ex, wr));
  endtask

  initial begin
    // Main count, borrow, pause/resume, expiry, clamping and load-priority vectors.
    vecs.push_back(mk("load_0102", 0, 0, 1, 16'h0102, 16'h0102, 0, 0, 0, 0));
    vecs.push_back(mk("start_0102", 1, 0, 0, 16'h0, 16'h0102, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk("hold_0102", 0, 0, 0, 16'h0, 16'h0102, 1, 0, 0, 0));
    vecs.push_back(mk("dec_0101", 0, 0, 0, 16'h0, 16'h0101, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk("hold_0101", 0, 0, 0, 16'h0, 16'h0101, 1, 0, 0, 0));
    vecs.push_back(mk("dec_0100", 0, 0, 0, 16'h0, 16'h0100, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk("hold_0100", 0, 0, 0, 16'h0, 16'h0100, 1, 0, 0, 0));
    vecs.push_back(mk("borrow_0059", 0, 0, 0, 16'h0, 16'h0059, 1, 0, 0, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk("tick_0059", 0, 0, 0, 16'h0, 16'h0059, 1, 0, 0, 0));
    vecs.push_back(mk("pause", 0, 1, 0, 16'h0, 16'h0059, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) vecs.push_back(mk("paused_hold", 0, 0, 0, 16'h0, 16'h0059, 0, 0, 0, 0));
    vecs.push_back(mk("resume", 1, 0, 0, 16'h0, 16'h0059, 1, 0, 0, 0));
    vecs.push_back(mk("resume_tick", 0, 0, 0, 16'h0, 16'h0059, 1, 0, 0, 0));
    vecs.push_back(mk("resume_dec_0058", 0, 0, 0, 16'h0, 16'h0058, 1, 0, 0, 0));
    vecs.push_back(mk("start_pause_run", 1, 1, 0, 16'h0, 16'h0058, 0, 0, 0, 0));
    vecs.push_back(mk("start_pause_paused", 1, 1, 0, 16'h0, 16'h0058, 0, 0, 0, 0));
    vecs.push_back(mk("resume2", 1, 0, 0, 16'h0, 16'h0058, 1, 0, 0, 0));
    vecs.push_back(mk("load_0001", 0, 0, 1, 16'h0001, 16'h0001, 0, 0, 0, 0));
    vecs.push_back(mk("start_0001", 1, 0, 0, 16'h0, 16'h0001, 1, 0, 0, WARN_ON));
    for (int i = 0; i < 3; i++) vecs.push_back(mk("hold_0001", 0, 0, 0, 16'h0, 16'h0001, 1, 0, 0, WARN_ON));
    vecs.push_back(mk("expire", 0, 0, 0, 16'h0, 16'h0000, 0, 1, 1, 0));
    vecs.push_back(mk("expire_once", 0, 0, 0, 16'h0, 16'h0000, 0, 1, 0, 0));
    vecs.push_back(mk("done_start", 1, 0, 0, 16'h0, 16'h0000, 0, 1, 0, 0));
    vecs.push_back(mk("done_pause", 0, 1, 0, 16'h0, 16'h0000, 0, 1, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk("done_hold", 0, 0, 0, 16'h0, 16'h0000, 0, 1, 0, 0));
    vecs.push_back(mk("load_clamp", 0, 0, 1, 16'hFA7C, 16'h9959, 0, 0, 0, 0));
    vecs.push_back(mk("load_0000", 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk("start_at_zero", 1, 0, 0, 16'h0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk("load_wins_start", 1, 0, 1, 16'h0102, 16'h0102, 0, 0, 0, 0));
    vecs.push_back(mk("start_again", 1, 0, 0, 16'h0, 16'h0102, 1, 0, 0, 0));
    vecs.push_back(mk("load_in_run", 0, 0, 1, 16'h0300, 16'h0300, 0, 0, 0, 0));
    vecs.push_back(mk("idle_no_count", 0, 0, 0, 16'h0, 16'h0300, 0, 0, 0, 0));

    rst = 1'b1; start = 1'b0; pause = 1'b0; load = 1'b0; load_val = 16'h0;
    @(negedge clk);
    check(mk("reset_state", 0, 0, 0, 16'h0, 16'h0300, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) step(vecs[i]);

    // 00:12 down to expiry: warn window and the 00:10 -> 00:09 borrow.
    step(mk("warn_load", 0, 0, 1, 16'h0012, 16'h0012, 0, 0, 0, 0));
    step(mk("warn_start", 1, 0, 0, 16'h0, 16'h0012, 1, 0, 0, 0));
    for (int s = 12; s >= 1; s--) begin
      for (int k = 0; k < TD - 1; k++)
        idle_exp("warn_hold", bcd_s(s), 1'b1, 1'b0, 1'b0, WARN_ON && (s <= 10));
      if (s == 1) idle_exp("warn_expire", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
      else        idle_exp("warn_dec", bcd_s(s - 1), 1'b1, 1'b0, 1'b0, WARN_ON && (s - 1 <= 10));
    end
    idle_exp("warn_done", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between clock edges while counting.
    step(mk("arst_load", 0, 0, 1, 16'h0102, 16'h0102, 0, 0, 0, 0));
    step(mk("arst_start", 1, 0, 0, 16'h0, 16'h0102, 1, 0, 0, 0));
    for (int k = 0; k < TD - 1; k++) idle_exp("arst_hold", 16'h0102, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check(mk("async_reset", 0, 0, 0, 16'h0, 16'h0300, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    idle_exp("post_reset_idle", 16'h0300, 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk("post_reset_start", 1, 0, 0, 16'h0, 16'h0300, 1, 0, 0, 0));

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
